// File: rtl/spi_pkg.sv
// Purpose: shared types and sizing constants for the SPI burst controller slice.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default frame width, FIFO pointer/count widths.
package spi_pkg;

   localparam int SPI_DATA_W     = 8;
   localparam int SPI_FIFO_DEPTH = 16;
   localparam int SPI_PTR_W      = $clog2(SPI_FIFO_DEPTH);
   localparam int SPI_CNT_W      = SPI_PTR_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } spi_state_e;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Purpose: bundles host TX/RX streams, burst control/status and SPI master handshake.
// Latency: none (wiring only).
// Backpressure: s_ready gates TX pushes; m_ready pops the RX head.
// Modports: slave = burst controller side, master = host / SPI master side.
interface spi_burst_ctrl_if
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_W,
   parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
) ();

   localparam int LEN_W = $clog2(FIFO_DEPTH) + 1;

   // host TX stream
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   // burst control / status
   logic [LEN_W-1:0]      burst_len;
   logic                  burst_go;
   logic                  busy;
   logic                  done;
   logic                  timeout_err;
   logic                  rx_overflow;
   // SPI master handshake
   logic                  spi_start;
   logic [DATA_WIDTH-1:0] spi_data;
   logic                  spi_finish;
   logic [DATA_WIDTH-1:0] spi_rx_data;
   // host RX stream
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport slave (
      input  s_data, s_valid, burst_len, burst_go, spi_finish, spi_rx_data, m_ready,
      output s_ready, busy, done, timeout_err, rx_overflow, spi_start, spi_data,
             m_data, m_valid
   );

   modport master (
      output s_data, s_valid, burst_len, burst_go, spi_finish, spi_rx_data, m_ready,
      input  s_ready, busy, done, timeout_err, rx_overflow, spi_start, spi_data,
             m_data, m_valid
   );

endinterface

// File: rtl/spi_sync_fifo.sv
// Purpose: single-clock show-ahead FIFO with full/empty/count status.
// Latency: write visible at rd_data one cycle after the push edge.
// Backpressure: push dropped when full unless a pop happens in the same cycle.
// Ports: clk/rst, wr_en/wr_data, rd_en/rd_data (head), full, empty, count.
module spi_sync_fifo
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_W,
   parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        rd_en,
   output logic [DATA_WIDTH-1:0]       rd_data,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  rd_ok, wr_ok;

   always_comb begin
      rd_ok = rd_en && (count_q != '0);
      // a pop in the same cycle frees the slot, so a full FIFO may still accept
      wr_ok = wr_en && ((count_q != CNT_W'(FIFO_DEPTH)) || rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: contents are only observable through count
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/spi_burst_ctrl.sv
// Purpose: burst sequencer feeding an SPI master from a TX FIFO and capturing replies into an RX FIFO.
// Latency: spi_start two cycles after accepted burst_go (TX non-empty); done one cycle after last finish rise.
// Backpressure: s_ready = TX not full; LOAD stalls on empty TX; RX words dropped (rx_overflow) when RX full.
// Ports: clk, rst (async active-high), bus (spi_burst_ctrl_if.slave: host TX/RX, burst ctrl/status, SPI handshake).
module spi_burst_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH     = SPI_DATA_W,
   parameter int FIFO_DEPTH     = SPI_FIFO_DEPTH,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic             clk,
   input logic             rst,
   spi_burst_ctrl_if.slave bus
);

   localparam int LEN_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   spi_state_e            state_q, state_d;
   logic [LEN_W-1:0]      remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
   logic                  spi_start_q, spi_start_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  rx_overflow_q, rx_overflow_d;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
   logic                  spi_finish_q;

   logic                  tx_wr, tx_rd, tx_full, tx_empty;
   logic [DATA_WIDTH-1:0] tx_head;
   logic [CNT_W-1:0]      tx_count, rx_count;
   logic                  rx_wr, rx_rd, rx_full, rx_empty;
   logic                  finish_rise;
   logic                  unused_counts;

   assign tx_wr       = bus.s_valid & ~tx_full;
   assign rx_rd       = bus.m_ready & ~rx_empty;
   assign finish_rise = bus.spi_finish & ~spi_finish_q;
   // occupancy is not needed here; full/empty carry all the flow control
   assign unused_counts = ^{tx_count, rx_count};

   spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst),
      .wr_en(tx_wr), .wr_data(bus.s_data),
      .rd_en(tx_rd), .rd_data(tx_head),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst),
      .wr_en(rx_wr), .wr_data(bus.spi_rx_data),
      .rd_en(rx_rd), .rd_data(bus.m_data),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      spi_data_d    = spi_data_q;
      spi_start_d   = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;
      rx_overflow_d = rx_overflow_q;
      to_cnt_d      = to_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      tx_rd         = 1'b0;
      rx_wr         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.burst_go) begin
               if (bus.burst_len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  remaining_d   = bus.burst_len;
                  timeout_err_d = 1'b0;
                  rx_overflow_d = 1'b0;
                  busy_d        = 1'b1;
                  state_d       = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            // waiting on an empty TX FIFO is a normal stall, not an error
            if (!tx_empty) begin
               tx_rd      = 1'b1;
               spi_data_d = tx_head;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            spi_start_d = 1'b1;
            to_cnt_d    = '0;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (finish_rise) begin
               rx_wr = 1'b1;
               // a same-cycle host pop makes room, so only a stalled full FIFO drops
               if (rx_full && !rx_rd) rx_overflow_d = 1'b1;
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q > LEN_W'(1)) begin
                  gap_cnt_d = '0;
                  state_d   = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (to_cnt_q == TO_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = ST_DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = ST_LOAD;
            else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         remaining_q   <= '0;
         spi_data_q    <= '0;
         spi_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         rx_overflow_q <= 1'b0;
         to_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         spi_finish_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         spi_data_q    <= spi_data_d;
         spi_start_q   <= spi_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         rx_overflow_q <= rx_overflow_d;
         to_cnt_q      <= to_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         // tracks the input in every state so a stale level never looks like an edge
         spi_finish_q  <= bus.spi_finish;
      end
   end

   assign bus.s_ready     = ~tx_full;
   assign bus.m_valid     = ~rx_empty;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.rx_overflow = rx_overflow_q;
   assign bus.spi_start   = spi_start_q;
   assign bus.spi_data    = spi_data_q;

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
- Burst sequencer directly upstream of the SPI master; owns that master's start/data/finish handshake.
- Host pushes TX words into an internal FIFO, then requests a burst of N frames.
- Block issues one master transaction per word, with a programmable idle gap between frames.
- Each word the master shifts in is captured into an RX FIFO for the host to drain.

Parameters:
DATA_WIDTH, 8, SPI frame width in bits
FIFO_DEPTH, 16, entries in each of TX and RX FIFOs (power of two, >=2)
GAP_CYCLES, 4, idle clk cycles between frame finish and next start (0 allowed)
TIMEOUT_CYCLES, 1024, max clk cycles waiting for master finish before abort

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
s_data  in  DATA_WIDTH  TX word from host
s_valid  in  1  TX push request
s_ready  out  1  TX FIFO not full
burst_len  in  $clog2(FIFO_DEPTH)+1  frames in burst, sampled with burst_go
burst_go  in  1  one-cycle burst request
busy  out  1  high from accepted burst_go until done
done  out  1  one-cycle pulse at burst end (normal or aborted)
timeout_err  out  1  sticky: last burst aborted on timeout
rx_overflow  out  1  sticky: RX word dropped because RX FIFO full
spi_start  out  1  one-cycle start pulse to SPI master
spi_data  out  DATA_WIDTH  word to SPI master, held stable for whole frame
spi_finish  in  1  master finish indication (edge-detected internally)
spi_rx_data  in  DATA_WIDTH  word received by master, valid at finish rising edge
m_data  out  DATA_WIDTH  RX FIFO head
m_valid  out  1  RX FIFO not empty
m_ready  in  1  host pops RX head when m_valid & m_ready

Behaviour:
- Reset (async assert, sync release): state IDLE, both FIFOs empty; busy, done, spi_start, timeout_err, rx_overflow all 0; spi_data 0; s_ready 1; m_valid 0.
- TX FIFO:
  - Push on s_valid & s_ready; s_valid while full is ignored.
  - Push is accepted in every state, including mid-burst.
- RX FIFO:
  - Show-ahead: m_data = head while m_valid.
  - Simultaneous push and pop when full is legal: pop first, no overflow.
- FSM states: IDLE, LOAD, START, WAIT, GAP, DONE.
  - IDLE: burst_go sampled at edge k. burst_len=0 goes to DONE (done pulse after edge k+1, no SPI traffic). Otherwise latch remaining=burst_len, clear both stickies, busy=1 from edge k, go LOAD.
  - LOAD: if TX FIFO non-empty, pop head into spi_data, go START. If empty, stall in LOAD (no error, no timeout).
  - START: spi_start=1 for exactly this one cycle; clear timeout counter; go WAIT. With TX non-empty, spi_start is high in the cycle after edge k+2.
  - WAIT: finish_rise = spi_finish & ~spi_finish_q (one registered delay).
    - On finish_rise: write spi_rx_data to RX FIFO; if full, drop the word and set rx_overflow. Then decrement remaining; go GAP if remaining>0, else DONE.
    - If the counter reaches TIMEOUT_CYCLES first: set timeout_err, go DONE. Unsent TX words stay in the FIFO.
  - GAP: count GAP_CYCLES cycles, then go LOAD. GAP_CYCLES=0 goes straight to LOAD.
  - DONE: done=1 for one cycle, busy drops the same edge, go IDLE.
- spi_data changes only in LOAD; it is held from START through WAIT.
- burst_go while busy is ignored. Stickies clear only on accepted burst_go or rst.
- spi_finish edges outside WAIT are ignored; edge-detect register still tracks the input.
- burst_len > FIFO_DEPTH is legal; the block refills from TX as the host pushes.
- rst mid-burst: immediate return to IDLE; spi_start forced 0; FIFO contents discarded.

Decomposition:
- Shared package spi_pkg: state encoding enum, DATA_WIDTH default, clog2-derived pointer/count width constant.
- One natural sub-module: spi_sync_fifo (parameterised DATA_WIDTH/FIFO_DEPTH, full/empty/count).
- spi_sync_fifo is instantiated twice, for TX and RX.

Test Plan:
- Push A5,9A; burst_len=2, GAP_CYCLES=4; loopback master model echoes 3C,C3. Required: two spi_start pulses with spi_data A5 then 9A; >=4 idle cycles between the first finish rise and the second start; m_data pops 3C then C3; done pulse; timeout_err=0.
- burst_len=3 with only 1 word in TX; push 2 more words 50 cycles later. Required: stall in LOAD, no timeout; 3 frames total; done after the third finish.
- burst_len=1 and master never asserts finish, TIMEOUT_CYCLES=64. Required: timeout_err=1 and done pulse 64 cycles after start; a later burst_go clears timeout_err.
- RX FIFO filled to 16 with m_ready=0, then a 1-frame burst. Required: rx_overflow=1, m_data still holds the oldest word, count stays 16.
- Assert rst during WAIT of the second frame of a 4-frame burst. Required: busy=0, spi_start=0, s_ready=1, m_valid=0 the cycle after rst asserts; stray finish after rst ignored.
- burst_go pulsed while busy and burst_len=0 while idle. Required: the first is ignored; the second gives a done pulse with no spi_start.
